// File: rtl/mdu_pkg.sv
// Shared op codes and FSM encoding for the iterative multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  // MULT/MULTU/DIV/DIVU share the multi-cycle datapath; op[1] selects divide, op[0] unsigned.
  function automatic logic is_arith(input logic [2:0] op);
    return op[2] == 1'b0;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on {acc, q}: shift-add multiply or restoring divide.
// Purely combinational; the caller registers the result once per cycle.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, b};
    rem     = {acc, q[WIDTH-1]};
    // acc < b holds between steps, so a successful subtract always fits in WIDTH bits
    diff    = rem[WIDTH-1:0] - b;
    acc_nxt = '0;
    q_nxt   = '0;
    if (is_div) begin
      if (rem >= {1'b0, b}) begin
        acc_nxt = diff;
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end else if (q[0]) begin
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[WIDTH-1:1]};
      q_nxt   = {acc[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULT/DIV unit with HI/LO; result and done WIDTH+1 edges after accept.
// No queueing: start is ignored while busy, the pipeline stalls on busy.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc, q, b;
  logic [WIDTH-1:0]   acc_nxt, q_nxt;
  logic               is_div, neg_q, neg_r, dz;
  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod;

  // Signed ops run on magnitudes; the sign is reapplied in FIX.
  assign sa    = ~op[0] & rs[WIDTH-1];
  assign sb    = ~op[0] & rt[WIDTH-1];
  assign abs_a = sa ? -rs : rs;
  assign abs_b = sb ? -rt : rt;
  assign prod  = {acc, q};

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .q       (q),
    .b       (b),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      q           <= '0;
      b           <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && is_arith(op)) begin
            acc         <= '0;
            q           <= abs_a;
            b           <= abs_b;
            is_div      <= op[1];
            neg_q       <= sa ^ sb;
            neg_r       <= sa;
            dz          <= op[1] & (rt == '0);
            cnt         <= CW'(WIDTH);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= RUN;
          end else if (start && op == OP_MTHI) begin
            HI          <= rs;
            div_by_zero <= 1'b0;
          end else if (start && op == OP_MTLO) begin
            LO          <= rs;
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            // Divide by zero leaves the dividend in acc, so HI naturally returns rs.
            LO <= dz ? '1 : (neg_q ? -q : q);
            HI <= neg_r ? -acc : acc;
          end else begin
            {HI, LO} <= neg_q ? -prod : prod;
          end
          div_by_zero <= dz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
